// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - issue/result bundle between the core and the HI/LO unit
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        md_stall;

  modport master (
    output start, md_op, A, B,
    input  HI, LO, busy, md_stall
  );

  modport slave (
    input  start, md_op, A, B,
    output HI, LO, busy, md_stall
  );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - MIPS HI/LO multiply/divide unit; divider built only with MD_UNIT_DIV_EN
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave md
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic             is_mul;
  logic             is_div;
  logic             accept;
  logic [63:0]      prod_s;
  logic [63:0]      prod_u;

  assign is_mul = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU);
`ifdef MD_UNIT_DIV_EN
  assign is_div = (md.md_op == OP_DIV) || (md.md_op == OP_DIVU);
`else
  assign is_div = 1'b0;
`endif

  assign accept      = md.start && (state == S_IDLE) && (is_mul || is_div);
  assign md.busy     = (state == S_RUN);
  assign md.md_stall = md.busy | (md.start & (is_mul | is_div));
  assign md.HI       = hi;
  assign md.LO       = lo;

  // Both products come from the captured operands, never the live bus.
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

`ifdef MD_UNIT_DIV_EN
  logic [31:0] div_q;
  logic [31:0] div_r;

  always_comb begin
    div_q = '0;
    div_r = '0;
    if (b_q == 32'd0) begin
      div_q = '0;
    end else if (op_q == OP_DIV) begin
      // The only signed quotient that overflows 32 bits wraps back to the dividend.
      if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
        div_q = 32'h8000_0000;
        div_r = '0;
      end else begin
        div_q = $unsigned($signed(a_q) / $signed(b_q));
        div_r = $unsigned($signed(a_q) % $signed(b_q));
      end
    end else begin
      div_q = a_q / b_q;
      div_r = a_q % b_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= md.md_op;
            a_q   <= md.A;
            b_q   <= md.B;
            cnt   <= is_mul ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
            state <= S_RUN;
          end else if (md.start && md.md_op == OP_MTHI) begin
            hi <= md.A;
          end else if (md.start && md.md_op == OP_MTLO) begin
            lo <= md.A;
          end
        end
        S_RUN: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            if (op_q == OP_MULT) begin
              {hi, lo} <= prod_s;
            end else if (op_q == OP_MULTU) begin
              {hi, lo} <= prod_u;
            end
`ifdef MD_UNIT_DIV_EN
            // Divide by zero burns the full latency but leaves HI/LO untouched.
            else if (b_q != 32'd0) begin
              hi <= div_r;
              lo <= div_q;
            end
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized self-checking bench for md_unit against an arithmetic HI/LO model
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MD_UNIT_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  int          checks;
  int          errors;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  function automatic bit is_long(logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2) || (DIV_EN && (op == 3'd3 || op == 3'd4));
  endfunction

  function automatic int latency(logic [2:0] op);
    return (op == 3'd1 || op == 3'd2) ? MULT_N : DIV_N;
  endfunction

  function automatic void model_apply(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd1: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd3: if (DIV_EN && b != 0) begin
        q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0];
      end
      3'd4: if (DIV_EN && b != 0) begin exp_lo = a / b; exp_hi = a % b; end
      3'd5: exp_hi = a;
      3'd6: exp_lo = a;
      default: ;
    endcase
  endfunction

  task automatic check_hilo(string name);
    checks++;
    if (bus.HI !== exp_hi) begin
      errors++;
      $display("FAIL %s HI: got %h expected %h", name, bus.HI, exp_hi);
    end
    checks++;
    if (bus.LO !== exp_lo) begin
      errors++;
      $display("FAIL %s LO: got %h expected %h", name, bus.LO, exp_lo);
    end
  endtask

  task automatic run_op(logic [2:0] op, logic [31:0] a, logic [31:0] b, string name);
    int cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.B = b;
    #1;
    checks++;
    if (bus.md_stall !== is_long(op)) begin
      errors++;
      $display("FAIL %s md_stall: got %b expected %b", name, bus.md_stall, is_long(op));
    end
    @(negedge clk);
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    #1;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (cnt != (is_long(op) ? latency(op) : 0)) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, cnt,
               is_long(op) ? latency(op) : 0);
    end
    model_apply(op, a, b);
    check_hilo(name);
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.md_op = '0; bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    exp_hi = '0; exp_lo = '0;
    check_hilo("reset");
    checks++;
    if (bus.busy !== 1'b0 || bus.md_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset busy/stall: got %b/%b expected 0/0", bus.busy, bus.md_stall);
    end
  endtask

  task automatic test_mult();
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    checks++;
    if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_literal: got %h_%h expected ffffffff_fffffffa", bus.HI, bus.LO);
    end
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    checks++;
    if (bus.HI !== 32'hFFFF_FFFE || bus.LO !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_literal: got %h_%h expected fffffffe_00000001", bus.HI, bus.LO);
    end
  endtask

  task automatic test_div();
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
`ifdef MD_UNIT_DIV_EN
    checks++;
    if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_literal: got %h_%h expected ffffffff_fffffffd", bus.HI, bus.LO);
    end
`endif
    run_op(3'd4, 32'd7, 32'd0, "divu_by_zero");
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_op(3'd4, 32'hFFFF_FFF0, 32'd3, "divu_big");
  endtask

  task automatic test_mthi_mtlo();
    run_op(3'd5, 32'h1234_5678, 32'd0, "mthi");
    run_op(3'd6, 32'h9ABC_DEF0, 32'd0, "mtlo");
    checks++;
    if (bus.HI !== 32'h1234_5678 || bus.LO !== 32'h9ABC_DEF0) begin
      errors++;
      $display("FAIL mtx_literal: got %h_%h expected 12345678_9abcdef0", bus.HI, bus.LO);
    end
    run_op(3'd0, 32'hDEAD_BEEF, 32'd1, "op_none");
    run_op(3'd7, 32'hDEAD_BEEF, 32'd1, "op_reserved");
  endtask

  task automatic test_ignore_while_busy();
    logic [31:0] a1;
    logic [31:0] b1;
    int cnt;
    a1 = $urandom; b1 = $urandom;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd1; bus.A = a1; bus.B = b1;
    @(negedge clk);
    bus.md_op = 3'd5; bus.A = $urandom;
    @(negedge clk);
    bus.md_op = 3'd2; bus.A = $urandom; bus.B = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (cnt != MULT_N - 2) begin
      errors++;
      $display("FAIL ignore_busy_len: got %0d expected %0d", cnt, MULT_N - 2);
    end
    model_apply(3'd1, a1, b1);
    check_hilo("ignore_while_busy");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    int cnt;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd2; bus.A = a1; bus.B = b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == MULT_N) begin
        bus.start = 1'b1; bus.md_op = 3'd5; bus.A = 32'hBAD0_BAD0;
      end
      @(negedge clk);
      #1;
    end
    model_apply(3'd2, a1, b1);
    check_hilo("completion_edge_mthi");
    bus.start = 1'b1; bus.md_op = 3'd1; bus.A = a2; bus.B = b2;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_accept: busy got %b expected 1", bus.busy);
    end
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (cnt != MULT_N) begin
      errors++;
      $display("FAIL back_to_back_len: got %0d expected %0d", cnt, MULT_N);
    end
    model_apply(3'd1, a2, b2);
    check_hilo("back_to_back");
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
      if ($urandom_range(0, 1) == 1) a = 32'($signed(a) >>> $urandom_range(0, 30));
      run_op(op, a, b, $sformatf("random_%0d_op%0d", i, op));
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] op;
    run_op(3'd5, 32'h5555_AAAA, 32'd0, "pre_abort_mthi");
    run_op(3'd6, 32'hA5A5_5A5A, 32'd0, "pre_abort_mtlo");
    op = DIV_EN ? 3'd3 : 3'd1;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_hi = '0; exp_lo = '0;
    check_hilo("reset_mid_op");
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: got %b expected 0", bus.busy);
    end
    repeat (DIV_N + 3) @(negedge clk);
    #1;
    check_hilo("no_late_write");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_ignore_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
